// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_sel.sv
// Operand bypass select for one Execute-stage source register; M beats W.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward selects, memory-wait FSM,
// wait timeout pulse and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             MemRead_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             BranchTaken_E,
  input  logic             MemReq_M,
  input  logic             MemReady,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(MEM_TIMEOUT - 2);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic              lu;
  logic              mw;
  logic              redirect;

  forward_sel u_fwd_a (
    .rs          (Rs1_E),
    .rd_m        (Rd_M),
    .rd_w        (Rd_W),
    .reg_write_m (RegWrite_M),
    .reg_write_w (RegWrite_W),
    .sel         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs          (Rs2_E),
    .rd_m        (Rd_M),
    .rd_w        (Rd_W),
    .reg_write_m (RegWrite_M),
    .reg_write_w (RegWrite_W),
    .sel         (fwd_b)
  );

  assign ForwardA_E = fwd_a;
  assign ForwardB_E = fwd_b;

  // Load-use check ignores whether the Decode instruction really reads rs1/rs2.
  assign lu = MemRead_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign mw = MemReq_M && !MemReady;
  assign redirect = !rst && !mw && BranchTaken_E;

  // Priority: reset, memory wait, redirect, load-use.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (rst) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
      Flush_W = 1'b1;
    end else if (mw) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (BranchTaken_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (lu) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (mw) state <= MEM_WAIT;
        MEM_WAIT: if (MemReady) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Wait counter saturates at the timeout value so the pulse fires only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else if (mw) begin
      if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + WAIT_W'(1);
      MemTimeout <= (wait_cnt == WAIT_PRE);
    end else begin
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (Stall_F)  StallCnt <= StallCnt + CNT_W'(1);
      if (redirect) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with a short memory timeout.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned MT    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic             MemRead_E, RegWrite_M, RegWrite_W, BranchTaken_E, MemReq_M, MemReady;
  logic             Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .MemRead_E(MemRead_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .BranchTaken_E(BranchTaken_E), .MemReq_M(MemReq_M), .MemReady(MemReady),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  // Packed view of {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,Flush_W}.
  logic [6:0] ctl;
  assign ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
    Rd_E = 5'd0; Rd_M = 5'd0; Rd_W = 5'd0;
    MemRead_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    BranchTaken_E = 1'b0; MemReq_M = 1'b0; MemReady = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000111) begin
      n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000111);
    end
    step();
    n_cmp++;
    if ({MemTimeout, StallCnt, FlushCnt} !== {1'b0, CNT_W'(0), CNT_W'(0)}) begin
      n_err++; $display("FAIL reset_regs: tmo=%b stall=%0d flush=%0d want 0/0/0", MemTimeout, StallCnt, FlushCnt);
    end
    n_cmp++;
    if (dut.state !== RUN) begin
      n_err++; $display("FAIL reset_state: got %0d want RUN", dut.state);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL idle_ctl: got %b want 0", ctl);
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a [5];
    logic [1:0] exp_b [5];
    exp_a = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    exp_b = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: begin Rs1_E = 5'd5; Rd_M = 5'd5; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1; end
        1: begin Rs1_E = 5'd5; Rd_M = 5'd0; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1; end
        2: begin Rs1_E = 5'd0; Rs2_E = 5'd0; RegWrite_M = 1'b1; RegWrite_W = 1'b1; end
        3: begin Rs1_E = 5'd9; Rs2_E = 5'd12; Rd_M = 5'd12; RegWrite_M = 1'b1; Rd_W = 5'd9; RegWrite_W = 1'b0; end
        default: begin Rs1_E = 5'd3; Rs2_E = 5'd3; Rd_M = 5'd3; RegWrite_M = 1'b0;
                       Rd_W = 5'd3; RegWrite_W = 1'b1; Rs2_E = 5'd4; Rd_M = 5'd4; RegWrite_M = 1'b1; end
      endcase
      #1;
      n_cmp++;
      if (ForwardA_E !== exp_a[i]) begin
        n_err++; $display("FAIL fwd_a[%0d]: got %b want %b", i, ForwardA_E, exp_a[i]);
      end
      n_cmp++;
      if (ForwardB_E !== exp_b[i]) begin
        n_err++; $display("FAIL fwd_b[%0d]: got %b want %b", i, ForwardB_E, exp_b[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_E = 1'b1; Rd_E = 5'd7; Rs2_D = 5'd7; Rs1_D = 5'd1;
    #1;
    n_cmp++;
    if (ctl !== 7'b1100010) begin
      n_err++; $display("FAIL lu_ctl: got %b want %b", ctl, 7'b1100010);
    end
    step();
    MemRead_E = 1'b0; Rd_E = 5'd0;
    #1;
    n_cmp++;
    if (StallCnt !== CNT_W'(1)) begin
      n_err++; $display("FAIL lu_stallcnt: got %0d want 1", StallCnt);
    end
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL lu_bubble_once: got %b want 0", ctl);
    end
    MemRead_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL lu_x0: got %b want 0", ctl);
    end
    idle_inputs();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    MemRead_E = 1'b1; Rd_E = 5'd7; Rs1_D = 5'd7; BranchTaken_E = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000110) begin
      n_err++; $display("FAIL br_ctl: got %b want %b", ctl, 7'b0000110);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (FlushCnt !== CNT_W'(1) || StallCnt !== CNT_W'(0)) begin
      n_err++; $display("FAIL br_cnt: flush=%0d stall=%0d want 1/0", FlushCnt, StallCnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReq_M = 1'b1; MemReady = 1'b0; BranchTaken_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== 7'b1111001) begin
        n_err++; $display("FAIL mw_ctl[%0d]: got %b want %b", i, ctl, 7'b1111001);
      end
      step();
    end
    MemReady = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000110) begin
      n_err++; $display("FAIL mw_release: got %b want %b", ctl, 7'b0000110);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (dut.state !== RUN) begin
      n_err++; $display("FAIL mw_state: got %0d want RUN", dut.state);
    end
    n_cmp++;
    if (StallCnt !== CNT_W'(3) || FlushCnt !== CNT_W'(1)) begin
      n_err++; $display("FAIL mw_cnt: stall=%0d flush=%0d want 3/1", StallCnt, FlushCnt);
    end
    // Ready in the very first request cycle: no stall, no state change.
    MemReq_M = 1'b1; MemReady = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL mw_ready_first: got %b want 0", ctl);
    end
    step();
    n_cmp++;
    if (dut.state !== RUN) begin
      n_err++; $display("FAIL mw_ready_state: got %0d want RUN", dut.state);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    MemReq_M = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (MemTimeout !== (i == 3)) begin
        n_err++; $display("FAIL tmo_pulse[%0d]: got %b want %b", i, MemTimeout, (i == 3));
      end
      if (MemTimeout === 1'b1) pulses++;
      n_cmp++;
      if (Stall_F !== 1'b1 || Stall_M !== 1'b1) begin
        n_err++; $display("FAIL tmo_stall[%0d]: got F=%b M=%b want 1/1", i, Stall_F, Stall_M);
      end
      step();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL tmo_count: got %0d want 1", pulses);
    end
    MemReady = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0 || MemTimeout !== 1'b0) begin
      n_err++; $display("FAIL tmo_release: ctl=%b tmo=%b want 0/0", ctl, MemTimeout);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    MemReq_M = 1'b1; MemReady = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000111) begin
      n_err++; $display("FAIL rstw_ctl: got %b want %b", ctl, 7'b0000111);
    end
    step();
    n_cmp++;
    if (dut.state !== RUN || StallCnt !== CNT_W'(0) || FlushCnt !== CNT_W'(0) || MemTimeout !== 1'b0) begin
      n_err++; $display("FAIL rstw_regs: state=%0d stall=%0d flush=%0d tmo=%b want RUN/0/0/0",
                        dut.state, StallCnt, FlushCnt, MemTimeout);
    end
    rst = 1'b0;
    idle_inputs();
    #1;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
